logic_unit_nbit: RTL and testbench

- Parametrised, registered successor to the ALU's 8-bit AND slice.
- Performs one of 8 bitwise ops on WIDTH-bit operands. Result and status flags are registered behind a valid/ready handshake.
- Internal accumulator can replace operand b, so bitwise reductions can be chained across transactions.
- Sits between the ALU operand/decode stage and the ALU result mux. Also exposes a saturating count of accepted operations.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/logic_core_nbit.sv | 40 ++++
 rtl/logic_unit_nbit.sv | 114 +++++++++++
 tb/tb_logic_unit_nbit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: bitwise op codes used by the logic unit and the
// ALU decode stage, plus a helper for the result status flags.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // Status flags that travel with every registered result.
  typedef struct packed {
    logic zero;
    logic all_ones;
    logic parity;
  } flags_t;

endpackage

// File: rtl/logic_core_nbit.sv
// Combinational bitwise core: applies one of eight ops to a and x and derives
// the zero / all-ones / parity flags from the result.
module logic_core_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] x,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             all_ones,
  output logic             parity
);

  // Op decode; every encoding is defined so no default path is reachable.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & x;
      OP_OR:   result = a | x;
      OP_XOR:  result = a ^ x;
      OP_NAND: result = ~(a & x);
      OP_NOR:  result = ~(a | x);
      OP_XNOR: result = ~(a ^ x);
      OP_NOT:  result = ~a;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  // Flags are taken from the freshly computed result so they always match it.
  always_comb begin
    zero     = (result == '0);
    all_ones = (result == {WIDTH{1'b1}});
    parity   = ^result;
  end

endmodule

// File: rtl/logic_unit_nbit.sv
// Registered N-bit logic unit: one-beat-per-cycle valid/ready pipeline stage
// around logic_core_nbit, with a chaining accumulator and a saturating count
// of accepted beats.
module logic_unit_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             all_ones,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;

  // The stage can take a beat when empty or when its result leaves this cycle.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    x_sel    = acc_sel ? acc_q : b;
  end

  logic_core_nbit #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (a),
    .x        (x_sel),
    .op       (op),
    .result   (core_result),
    .zero     (core_flags.zero),
    .all_ones (core_flags.all_ones),
    .parity   (core_flags.parity)
  );

  // Next-state: load on accept, drain on ready, clear of acc wins over update.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = core_result;
      flags_d     = core_flags;
      acc_d       = core_result;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (acc_clr) begin
      acc_d = '0;
    end
  end

  // State registers with synchronous active-low reset; a pending result is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid = out_valid_q;
    out       = out_q;
    zero      = flags_q.zero;
    all_ones  = flags_q.all_ones;
    parity    = flags_q.parity;
    acc       = acc_q;
    txn_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_logic_unit_nbit.sv
// Scoreboard bench for logic_unit_nbit: a driver issues beats and pushes
// expected results from a reference model; a monitor compares whatever the
// DUT presents. A second instance covers WIDTH=16 and counter saturation.
module tb_logic_unit_nbit;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       ao;
    logic       p;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       acc_sel = 1'b0, acc_clr = 1'b0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] out, acc;
  logic       zero, all_ones, parity;
  logic [15:0] txn_cnt;

  logic        in_valid1 = 1'b0, in_ready1;
  logic [15:0] a1 = '0, b1 = '0;
  logic [2:0]  op1 = '0;
  logic        out_valid1;
  logic [15:0] out1, acc1;
  logic        zero1, all_ones1, parity1;
  logic [1:0]  txn_cnt1;

  exp_t        sb_q[$];

  logic        m_valid;
  logic [7:0]  m_acc;
  int          m_cnt;

  always #5 clk = ~clk;

  logic_unit_nbit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .all_ones(all_ones), .parity(parity),
    .acc(acc), .txn_cnt(txn_cnt)
  );

  logic_unit_nbit #(.WIDTH(16), .CNT_W(2)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .op(op1), .acc_sel(1'b0), .acc_clr(1'b0),
    .out_valid(out_valid1), .out_ready(1'b1), .out(out1),
    .zero(zero1), .all_ones(all_ones1), .parity(parity1),
    .acc(acc1), .txn_cnt(txn_cnt1)
  );

  function automatic logic [15:0] ref_op(input logic [15:0] av, input logic [15:0] xv,
                                         input int opc, input logic [15:0] mask);
    logic [15:0] r;
    case (opc)
      0: r = av & xv;
      1: r = av | xv;
      2: r = av ^ xv;
      3: r = ~(av & xv);
      4: r = ~(av | xv);
      5: r = ~(av ^ xv);
      6: r = ~av;
      default: r = av;
    endcase
    return r & mask;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; model is advanced for the edge that follows.
  task automatic beat(input logic [7:0] av, input logic [7:0] bv, input int opc,
                      input logic sel, input logic clr, input logic v, input logic rdy);
    logic       exp_rdy;
    logic [7:0] r;
    exp_t       e;
    a = av; b = bv; op = 3'(opc); acc_sel = sel; acc_clr = clr;
    in_valid = v; out_ready = rdy;
    @(negedge clk);
    exp_rdy = !m_valid || rdy;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("acc", {24'b0, acc}, {24'b0, m_acc});
    chk("txn_cnt", {16'b0, txn_cnt}, m_cnt);
    if (v && exp_rdy) begin
      r = 8'(ref_op({8'b0, av}, {8'b0, sel ? m_acc : bv}, opc, 16'h00FF));
      e.res = r;
      e.z   = (r == 8'h00);
      e.ao  = (r == 8'hFF);
      e.p   = ($countones(r) % 2) == 1;
      sb_q.push_back(e);
      m_valid = 1'b1;
      m_acc   = r;
      if (m_cnt < 65535) m_cnt++;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (clr) m_acc = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    m_valid = 1'b0; m_acc = '0; m_cnt = 0;
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst out", {24'b0, out}, 0);
    chk("rst zero", {31'b0, zero}, 0);
    chk("rst all_ones", {31'b0, all_ones}, 0);
    chk("rst parity", {31'b0, parity}, 0);
    chk("rst acc", {24'b0, acc}, 0);
    chk("rst txn_cnt", {16'b0, txn_cnt}, 0);
    chk("rst in_ready", {31'b0, in_ready}, 1);
  endtask

  // Monitor: compare the presented result every cycle it is valid (this also
  // checks hold stability), retire it when the downstream takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected out_valid", 1, 0);
        end else begin
          e = sb_q[0];
          chk("out", {24'b0, out}, {24'b0, e.res});
          chk("zero", {31'b0, zero}, {31'b0, e.z});
          chk("all_ones", {31'b0, all_ones}, {31'b0, e.ao});
          chk("parity", {31'b0, parity}, {31'b0, e.p});
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_valid = 1'b0; m_acc = '0; m_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic ops, back-to-back with out_ready=1.
    beat(8'h00, 8'hD3, 0, 0, 0, 1, 1);
    beat(8'hFF, 8'h00, 0, 0, 0, 1, 1);
    beat(8'hFF, 8'hFF, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) beat(8'hAA, 8'hCC, i, 0, 0, 1, 1);
    // Complement pair.
    beat(8'hEC, 8'h13, 0, 0, 0, 1, 1);
    beat(8'hEC, 8'h13, 1, 0, 0, 1, 1);
    beat(8'hEC, 8'h13, 2, 0, 0, 1, 1);
    beat(8'hEC, 8'h13, 6, 0, 0, 1, 1);
    beat(8'h00, 8'h00, 0, 0, 0, 0, 1);

    // Backpressure: 88 held for 3 cycles, then OR goes through.
    do_reset();
    beat(8'hAA, 8'hCC, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) beat(8'hAA, 8'hCC, 1, 0, 0, 1, 0);
    chk("bp held out", {24'b0, out}, 32'h88);
    chk("bp held cnt", {16'b0, txn_cnt}, 1);
    beat(8'hAA, 8'hCC, 1, 0, 0, 1, 1);
    chk("bp release out", {24'b0, out}, 32'hEE);
    chk("bp release cnt", {16'b0, txn_cnt}, 2);

    // Accumulator chain and clear-with-use.
    beat(8'h00, 8'h00, 0, 0, 1, 0, 1);
    beat(8'h01, 8'h00, 1, 1, 0, 1, 1);
    beat(8'h02, 8'h00, 1, 1, 0, 1, 1);
    beat(8'h04, 8'h00, 1, 1, 0, 1, 1);
    beat(8'h08, 8'h00, 1, 1, 0, 1, 1);
    chk("chain out", {24'b0, out}, 32'h0F);
    chk("chain acc", {24'b0, acc}, 32'h0F);
    beat(8'hFF, 8'h00, 0, 1, 1, 1, 1);
    chk("clr+use out", {24'b0, out}, 32'h0F);
    chk("clr+use acc", {24'b0, acc}, 32'h00);

    // Reset while a result is stalled.
    beat(8'h00, 8'h00, 0, 0, 1, 0, 1);
    beat(8'h5A, 8'h00, 7, 0, 0, 1, 0);
    beat(8'h00, 8'h00, 0, 0, 0, 0, 0);
    chk("pre-rst acc", {24'b0, acc}, 32'h5A);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      beat(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
           1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0));
    end
    beat(8'h00, 8'h00, 0, 0, 0, 0, 1);
    beat(8'h00, 8'h00, 0, 0, 0, 0, 1);
    chk("scoreboard drained", sb_q.size(), 0);

    // WIDTH=16, CNT_W=2 instance: saturation and wide op.
    a1 = 16'hFFFF; b1 = 16'h0F0F; op1 = 3'b010; in_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("w16 txn_cnt", {30'b0, txn_cnt1}, (i + 1 > 3) ? 3 : i + 1);
      chk("w16 out", {16'b0, out1}, {16'b0, ref_op(16'hFFFF, 16'h0F0F, 2, 16'hFFFF)});
      chk("w16 out_valid", {31'b0, out_valid1}, 1);
    end
    in_valid1 = 1'b0;
    chk("w16 parity", {31'b0, parity1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
